// File: rtl/minterm_pkg.sv
// Shared types and defaults for the minterm_sweep truth-table sequencer.
package minterm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    LAST,
    DONE
  } state_e;

  localparam int unsigned DEFAULT_N_VARS   = 4;
  localparam logic [15:0] DEFAULT_EXPECTED = 16'h16C5;  // m(0,2,6,7,9,10,12)
  localparam int unsigned SETTLE_W         = 4;         // SETTLE range 0..15

endpackage

// File: rtl/minterm_sweep_if.sv
// Handshake/result bundle between minterm_sweep and its driver plus the function under test.
interface minterm_sweep_if
  import minterm_pkg::*;
#(
  parameter int unsigned N_VARS = DEFAULT_N_VARS
);
  localparam int unsigned N_MINTERMS = 2 ** N_VARS;

  logic                  start;
  logic [N_VARS-1:0]     vec;
  logic                  f;
  logic                  busy;
  logic                  done;
  logic [N_MINTERMS-1:0] table_out;
  logic                  pass;
  logic [N_VARS:0]       mismatch_cnt;

  modport master (
    output start, f,
    input  vec, busy, done, table_out, pass, mismatch_cnt
  );

  modport slave (
    input  start, f,
    output vec, busy, done, table_out, pass, mismatch_cnt
  );
endinterface

// File: rtl/minterm_sweep_counter.sv
// Vector counter with per-vector settle delay; flags the sample cycle and the final vector.
module sweep_counter
  import minterm_pkg::*;
#(
  parameter int unsigned N_VARS = DEFAULT_N_VARS,
  parameter int unsigned SETTLE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_en,
  output logic [N_VARS-1:0] o_vec,
  output logic              o_sample_en,
  output logic              o_last
);
  localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE);

  logic [N_VARS-1:0]   r_vec;
  logic [SETTLE_W-1:0] r_settle;

  assign o_sample_en = i_en && (r_settle == SETTLE_MAX);
  assign o_last      = o_sample_en && (r_vec == '1);
  assign o_vec       = r_vec;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_vec    <= '0;
      r_settle <= '0;
    end else if (o_sample_en) begin
      r_vec    <= r_vec + N_VARS'(1);  // wraps to 0 after the last vector
      r_settle <= '0;
    end else if (i_en) begin
      r_settle <= r_settle + SETTLE_W'(1);
    end
  end
endmodule

// File: rtl/minterm_sweep.sv
// Sweeps a 4-input function through all minterms and captures its truth table.
// Optional mask comparator enabled by defining MINTERM_SWEEP_CHECK_EN.
module minterm_sweep
  import minterm_pkg::*;
#(
  parameter int unsigned         N_VARS   = DEFAULT_N_VARS,
  parameter int unsigned         SETTLE   = 0,
  parameter logic [2**N_VARS-1:0] EXPECTED = DEFAULT_EXPECTED
) (
  input  logic            clk,
  input  logic            rst_n,
  minterm_sweep_if.slave  bus
);
  localparam int unsigned N_MINTERMS = 2 ** N_VARS;

  state_e                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic [N_VARS:0]       r_mismatch;
  logic [N_MINTERMS-1:0] r_capture;
  logic [N_MINTERMS-1:0] r_table;

  logic [N_VARS-1:0]     w_vec;
  logic                  w_sample_en;
  logic                  w_last;
  logic                  w_pass;
  logic [N_VARS:0]       w_mismatch;

  sweep_counter #(
    .N_VARS (N_VARS),
    .SETTLE (SETTLE)
  ) u_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (r_state == IDLE),
    .i_en        (r_state == SWEEP),
    .o_vec       (w_vec),
    .o_sample_en (w_sample_en),
    .o_last      (w_last)
  );

`ifdef MINTERM_SWEEP_CHECK_EN
  logic [N_MINTERMS-1:0] w_diff;

  assign w_diff = r_capture ^ EXPECTED;
  assign w_pass = (w_diff == '0);

  always_comb begin
    // NOTE: assign a default before the loop so no path leaves the output unassigned (no latch).
    w_mismatch = '0;
    for (int k = 0; k < N_MINTERMS; k++) begin
      w_mismatch = w_mismatch + {{N_VARS{1'b0}}, w_diff[k]};
    end
  end
`else
  // Comparator absent: the expected mask has no consumer in this build.
  logic w_unused_expected;
  assign w_unused_expected = ^EXPECTED;
  assign w_pass            = 1'b0;
  assign w_mismatch        = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_mismatch <= '0;
      r_table    <= '0;
      // NOTE: the capture register is reset too, so an aborted sweep leaves no partial table behind.
      r_capture  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state   <= SWEEP;
            r_busy    <= 1'b1;
            r_capture <= '0;
          end
        end
        SWEEP: begin
          if (w_sample_en) r_capture[w_vec] <= bus.f;
          if (w_last)      r_state          <= LAST;
        end
        LAST: begin
          r_table    <= r_capture;
          r_pass     <= w_pass;
          r_mismatch <= w_mismatch;
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_state    <= DONE;
        end
        DONE: r_state <= IDLE;
      endcase
    end
  end

  assign bus.vec          = w_vec;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.table_out    = r_table;
  assign bus.pass         = r_pass;
  assign bus.mismatch_cnt = r_mismatch;
endmodule
